// File: rtl/fft_frame_buffer_if.sv
// Sample-in / frame-read bus between the ADC framer and the FFT core.
interface fft_frame_buffer_if #(
  parameter int W     = 16,
  parameter int LOG2N = 3
);
  logic [W-1:0]     data_in;
  logic             dv;
  logic [LOG2N-1:0] rd_addr;
  logic [W-1:0]     rd_data;
  logic             frame_ready;
  logic             frame_done;
  logic             overflow;
  logic [7:0]       frame_count;
  logic             wr_bank;

  modport master (
    output data_in, dv, rd_addr, frame_done,
    input  rd_data, frame_ready, overflow, frame_count, wr_bank
  );

  modport slave (
    input  data_in, dv, rd_addr, frame_done,
    output rd_data, frame_ready, overflow, frame_count, wr_bank
  );
endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong framer: packs N strobed samples per bank, hands full banks to the FFT reader.
// Read data 1 cycle after address; no backpressure on input, samples arriving with both banks full are dropped.
module fft_frame_buffer #(
  parameter int W           = 16,
  parameter int N           = 8,
  parameter int LOG2N       = 3,
  parameter int BIT_REVERSE = 1,
  parameter int SIGNED_OUT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  fft_frame_buffer_if.slave  bus
);

  typedef enum logic {FILL, STALL} wr_state_t;

  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);

  wr_state_t        state, state_nxt;
  logic             wr_bank, wr_bank_nxt;
  logic             rd_bank, rd_bank_nxt;
  logic [LOG2N-1:0] wr_idx, wr_idx_nxt;
  logic [1:0]       bank_full, bank_full_nxt;
  logic             overflow, overflow_nxt;
  logic [7:0]       frame_count, frame_count_nxt;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr;
  logic [W-1:0]     wr_dat;
  logic             release_rd;
  logic [W-1:0]     rd_data;
  logic [W-1:0]     mem [2*N];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // A FRAME_DONE only counts when the reader actually holds a full bank.
  assign release_rd = bus.frame_done & bank_full[rd_bank];

  always_comb begin
    wr_addr = (BIT_REVERSE != 0) ? bitrev(wr_idx) : wr_idx;
    wr_dat  = (SIGNED_OUT != 0) ? {~bus.data_in[W-1], bus.data_in[W-2:0]} : bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_idx      <= '0;
      bank_full   <= 2'b00;
      overflow    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      wr_bank     <= wr_bank_nxt;
      rd_bank     <= rd_bank_nxt;
      wr_idx      <= wr_idx_nxt;
      bank_full   <= bank_full_nxt;
      overflow    <= overflow_nxt;
      frame_count <= frame_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wr_bank_nxt     = wr_bank;
    rd_bank_nxt     = rd_bank;
    wr_idx_nxt      = wr_idx;
    bank_full_nxt   = bank_full;
    overflow_nxt    = overflow;
    frame_count_nxt = frame_count;
    wr_en           = 1'b0;

    if (release_rd) begin
      bank_full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt            = ~rd_bank;
    end

    case (state)
      FILL: begin
        if (bus.dv) begin
          wr_en = 1'b1;
          if (wr_idx == IDX_LAST) begin
            wr_idx_nxt             = '0;
            bank_full_nxt[wr_bank] = 1'b1;
            frame_count_nxt        = frame_count + 8'd1;
            // The other bank is usable if empty or freed by the reader on this very edge.
            if (!bank_full[~wr_bank] || (release_rd && (rd_bank != wr_bank)))
              wr_bank_nxt = ~wr_bank;
            else
              state_nxt = STALL;
          end else begin
            wr_idx_nxt = wr_idx + IDX_ONE;
          end
        end
      end
      STALL: begin
        if (bus.dv) overflow_nxt = 1'b1;
        if (release_rd) begin
          wr_bank_nxt = ~wr_bank;
          wr_idx_nxt  = '0;
          state_nxt   = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[{wr_bank, wr_addr}] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[{rd_bank, bus.rd_addr}];
  end

  assign bus.rd_data     = rd_data;
  assign bus.frame_ready = bank_full[rd_bank];
  assign bus.overflow    = overflow;
  assign bus.frame_count = frame_count;
  assign bus.wr_bank     = wr_bank;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Drives two framer instances (bit-reversed/signed and natural/raw) with one stimulus stream, checks against a frame-queue model.
module tb_fft_frame_buffer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_frame_buffer_if #(.W(16), .LOG2N(3)) if0 ();
  fft_frame_buffer_if #(.W(16), .LOG2N(3)) if1 ();

  fft_frame_buffer #(.W(16), .N(8), .LOG2N(3), .BIT_REVERSE(1), .SIGNED_OUT(1)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  fft_frame_buffer #(.W(16), .N(8), .LOG2N(3), .BIT_REVERSE(0), .SIGNED_OUT(0)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  typedef logic [15:0] frame_t [8];

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: completed frames waiting for the reader, oldest first.
  frame_t      fq[$];
  logic [15:0] cur[$];
  logic        m_stall, m_ovf, m_wrb;
  logic [7:0]  m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input frame_t f, input logic [2:0] a, input bit br, input bit so);
    logic [2:0]  idx;
    logic [15:0] s;
    idx = br ? {a[0], a[1], a[2]} : a;
    s = f[idx];
    return so ? {~s[15], s[14:0]} : s;
  endfunction

  task automatic model_update(input logic rst, input logic d_v, input logic [15:0] d, input logic done);
    logic   stall0;
    frame_t f;
    if (rst) begin
      fq.delete();
      cur.delete();
      m_stall = 1'b0;
      m_ovf   = 1'b0;
      m_wrb   = 1'b0;
      m_cnt   = 8'd0;
      return;
    end
    stall0 = m_stall;
    if (done && fq.size() > 0) begin
      fq.delete(0);
      if (stall0) begin
        m_stall = 1'b0;
        m_wrb   = ~m_wrb;
      end
    end
    if (d_v) begin
      if (stall0) begin
        m_ovf = 1'b1;
      end else begin
        cur.push_back(d);
        if (cur.size() == 8) begin
          for (int i = 0; i < 8; i++) f[i] = cur[i];
          fq.push_back(f);
          cur.delete();
          m_cnt = m_cnt + 8'd1;
          if (fq.size() == 2) m_stall = 1'b1;
          else                m_wrb   = ~m_wrb;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic d_v, input logic [15:0] d,
                      input logic done, input logic [2:0] a);
    logic        exp_vld;
    logic [15:0] e0, e1;
    @(negedge clk);
    reset = rst;
    if0.dv = d_v;  if0.data_in = d;  if0.frame_done = done;  if0.rd_addr = a;
    if1.dv = d_v;  if1.data_in = d;  if1.frame_done = done;  if1.rd_addr = a;
    exp_vld = rst || (fq.size() > 0);
    e0 = 16'h0;
    e1 = 16'h0;
    if (!rst && fq.size() > 0) begin
      e0 = word(fq[0], a, 1'b1, 1'b1);
      e1 = word(fq[0], a, 1'b0, 1'b0);
    end
    @(posedge clk);
    cyc++;
    model_update(rst, d_v, d, done);
    #1;
    chk("ready0", 32'(if0.frame_ready), 32'(fq.size() > 0));
    chk("ready1", 32'(if1.frame_ready), 32'(fq.size() > 0));
    chk("ovf0",   32'(if0.overflow),    32'(m_ovf));
    chk("ovf1",   32'(if1.overflow),    32'(m_ovf));
    chk("cnt0",   32'(if0.frame_count), 32'(m_cnt));
    chk("cnt1",   32'(if1.frame_count), 32'(m_cnt));
    chk("wrb0",   32'(if0.wr_bank),     32'(m_wrb));
    chk("wrb1",   32'(if1.wr_bank),     32'(m_wrb));
    if (exp_vld) begin
      chk("rd0", 32'(if0.rd_data), 32'(e0));
      chk("rd1", 32'(if1.rd_data), 32'(e1));
    end
  endtask

  task automatic fill(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, base + 16'(k), 1'b0, 3'd0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 16'h0, 1'b0, 3'(a));
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{addr: 3'd0, exp0: 16'h0000, exp1: 16'h8000};
    vt[1] = '{addr: 3'd1, exp0: 16'h0004, exp1: 16'h8001};
    vt[2] = '{addr: 3'd3, exp0: 16'h0006, exp1: 16'h8003};
    vt[3] = '{addr: 3'd6, exp0: 16'h0003, exp1: 16'h8006};
    vt[4] = '{addr: 3'd7, exp0: 16'h0007, exp1: 16'h8007};
    vt[5] = '{addr: 3'd4, exp0: 16'h0001, exp1: 16'h8004};

    m_stall = 1'b0; m_ovf = 1'b0; m_wrb = 1'b0; m_cnt = 8'd0;

    // Reset state
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    chk("rst_ready", 32'(if0.frame_ready), 32'd0);
    chk("rst_ovf",   32'(if0.overflow),    32'd0);
    chk("rst_cnt",   32'(if0.frame_count), 32'd0);
    chk("rst_wrb",   32'(if0.wr_bank),     32'd0);
    chk("rst_rd",    32'(if0.rd_data),     32'd0);

    // Offset-binary samples, bit-reversed placement
    fill(7, 16'h8000);
    chk("pre_ready", 32'(if0.frame_ready), 32'd0);
    step(1'b0, 1'b1, 16'h8007, 1'b0, 3'd0);
    chk("t1_ready", 32'(if0.frame_ready), 32'd1);
    chk("t1_cnt",   32'(if0.frame_count), 32'd1);
    chk("t1_wrb",   32'(if0.wr_bank),     32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, vt[i].addr);
      chk("tbl_rd0", 32'(if0.rd_data), 32'(vt[i].exp0));
      chk("tbl_rd1", 32'(if1.rd_data), 32'(vt[i].exp1));
    end

    // Release frame 1, natural-order raw frame into bank 1
    step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    chk("t2_empty", 32'(if0.frame_ready), 32'd0);
    fill(8, 16'h1230);
    step(1'b0, 1'b0, 16'h0, 1'b0, 3'd5);
    chk("t2_rd1", 32'(if1.rd_data), 32'h1235);
    chk("t2_rd0", 32'(if0.rd_data), 32'h9235);
    read_all();

    // Both banks full, three samples dropped, then recovery
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    fill(8, 16'h0100);
    fill(8, 16'h0200);
    fill(3, 16'h0300);
    chk("t3_ovf", 32'(if0.overflow),    32'd1);
    chk("t3_cnt", 32'(if0.frame_count), 32'd2);
    chk("t3_wrb", 32'(if1.wr_bank),     32'd1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    chk("t3_ready", 32'(if0.frame_ready), 32'd1);
    read_all();
    fill(8, 16'h0400);
    step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    read_all();

    // Frame completion coinciding with release
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    fill(8, 16'h0500);
    fill(7, 16'h0600);
    step(1'b0, 1'b1, 16'h0607, 1'b1, 3'd0);
    chk("t4_ovf",   32'(if0.overflow),    32'd0);
    chk("t4_ready", 32'(if0.frame_ready), 32'd1);
    chk("t4_wrb",   32'(if0.wr_bank),     32'd0);
    read_all();

    // Reset mid-frame
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    fill(5, 16'h0700);
    step(1'b1, 1'b1, 16'h0705, 1'b0, 3'd0);
    chk("t5_cnt",   32'(if0.frame_count), 32'd0);
    chk("t5_ready", 32'(if0.frame_ready), 32'd0);
    fill(8, 16'h0800);
    step(1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    chk("t5_first", 32'(if1.rd_data), 32'h0800);

    // Stray FRAME_DONE, then frame counter wrap
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    chk("t6_ready", 32'(if0.frame_ready), 32'd0);
    chk("t6_wrb",   32'(if0.wr_bank),     32'd0);
    for (int f = 0; f < 256; f++) begin
      fill(8, 16'(f * 8));
      step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    end
    chk("t6_wrap", 32'(if0.frame_count), 32'd0);

    // Random traffic
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    for (int i = 0; i < 3000; i++) begin
      step(1'b0 || ($urandom_range(0, 799) == 0),
           ($urandom_range(0, 3) != 0),
           16'($urandom),
           ($urandom_range(0, 9) == 0),
           3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
